// File: rtl/fixed_deparser_if.sv
// Byte stream carrying deparsed header bytes toward the egress packet builder.
//   byte_o  : stream data byte
//   valid_o : byte_o valid
//   last_o  : final byte of the last present header
//   ready_i : sink accepts byte when valid_o & ready_i
// master = deparser side, slave = sink side.
interface fixed_deparser_if;
  logic [7:0] byte_o;
  logic       valid_o;
  logic       last_o;
  logic       ready_i;

  modport master (output byte_o, valid_o, last_o, input  ready_i);
  modport slave  (input  byte_o, valid_o, last_o, output ready_i);
endinterface

// File: rtl/fixed_deparser.sv
// Fixed-graph header deparser. Snapshots a header byte window plus per-header
// offsets on start, then streams every present header, in header-index order,
// one byte per cycle on a valid/ready stream.
// Ports:
//   clk, rst       : clock, async active-high reset
//   start_i        : deparse request, accepted only in IDLE
//   pkt_hdr_i      : header byte window, sampled on accepted start
//   parsed_hdrs_i  : per-header offset or NO_HEADER, sampled on accepted start
//   strm           : output byte stream (master)
//   busy_o         : high while emitting
//   done_o         : one-cycle completion pulse
//   len_o          : bytes emitted, held until next start
//   error_o        : a header overran the window, held until next start

// Per-header bound check: present if not NO_HEADER and the whole header fits.
// The sum is formed at 33 bits so huge offsets cannot wrap back into range.
module fixed_deparser_hdr_chk #(
  parameter int          HDR_MAX_LEN = 64,
  parameter logic [31:0] NO_HEADER   = 32'hFFFF_FFFF
) (
  input  logic [31:0] offset,
  input  logic [15:0] len,
  output logic        present,
  output logic        overrun
);
  logic [32:0] end_pos;
  logic        given;

  assign end_pos = {1'b0, offset} + {17'b0, len};
  assign given   = (offset != NO_HEADER);
  assign present = given && (end_pos <= 33'(HDR_MAX_LEN));
  assign overrun = given && (end_pos >  33'(HDR_MAX_LEN));
endmodule

module fixed_deparser #(
  parameter int          NUM_HEADERS = 3,
  parameter int          HDR_MAX_LEN = 64,
  parameter logic [31:0] NO_HEADER   = 32'hFFFF_FFFF,
  parameter int          HDR0_LEN    = 14,
  parameter int          HDR1_LEN    = 20,
  parameter int          HDR2_LEN    = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_i,
  input  logic [HDR_MAX_LEN-1:0][7:0]         pkt_hdr_i,
  input  logic [NUM_HEADERS-1:0][31:0]        parsed_hdrs_i,
  fixed_deparser_if.master                    strm,
  output logic                                busy_o,
  output logic                                done_o,
  output logic [15:0]                         len_o,
  output logic                                error_o
);
  localparam int AW = $clog2(HDR_MAX_LEN);
  localparam int IW = (NUM_HEADERS > 1) ? $clog2(NUM_HEADERS) : 1;
  localparam logic [NUM_HEADERS-1:0][15:0] LEN_TAB =
    {16'(HDR2_LEN), 16'(HDR1_LEN), 16'(HDR0_LEN)};

  typedef enum logic [1:0] {IDLE, EMIT, FINISH} state_t;

  function automatic logic [15:0] hdr_len(input logic [IW-1:0] i);
    case (i)
      IW'(0):  hdr_len = 16'(HDR0_LEN);
      IW'(1):  hdr_len = 16'(HDR1_LEN);
      IW'(2):  hdr_len = 16'(HDR2_LEN);
      default: hdr_len = 16'd0;
    endcase
  endfunction

  function automatic logic [IW-1:0] lowest(input logic [NUM_HEADERS-1:0] m);
    lowest = '0;
    for (int i = NUM_HEADERS-1; i >= 0; i--)
      if (m[i]) lowest = IW'(i);
  endfunction

  // bound check per header slot
  logic [NUM_HEADERS-1:0] hit, ovr;
  fixed_deparser_hdr_chk #(.HDR_MAX_LEN(HDR_MAX_LEN), .NO_HEADER(NO_HEADER))
    u_chk [NUM_HEADERS-1:0] (
      .offset (parsed_hdrs_i),
      .len    (LEN_TAB),
      .present(hit),
      .overrun(ovr)
    );

  state_t                          state_q, state_n;
  logic [HDR_MAX_LEN-1:0][7:0]     snap_q, snap_n;
  logic [NUM_HEADERS-1:0][AW-1:0]  offs_q, offs_n;
  logic [NUM_HEADERS-1:0]          mask_q, mask_n, rem;
  logic [IW-1:0]                   idx_q, idx_n;
  logic [15:0]                     cnt_q, cnt_n;
  logic [15:0]                     len_n;
  logic                            err_n;
  logic [AW-1:0]                   addr_n;
  logic                            last_n;

  always_comb begin
    state_n = state_q;
    snap_n  = snap_q;
    offs_n  = offs_q;
    mask_n  = mask_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    len_n   = len_o;
    err_n   = error_o;
    rem     = '0;
    case (state_q)
      IDLE: if (start_i) begin
        snap_n = pkt_hdr_i;
        for (int i = 0; i < NUM_HEADERS; i++) offs_n[i] = parsed_hdrs_i[i][AW-1:0];
        mask_n = hit;
        err_n  = |ovr;
        len_n  = '0;
        idx_n  = lowest(hit);
        cnt_n  = '0;
        state_n = (|hit) ? EMIT : FINISH;
      end
      EMIT: if (strm.ready_i) begin
        len_n = len_o + 16'd1;
        if (cnt_q == hdr_len(idx_q) - 16'd1) begin
          rem    = mask_q & ~(NUM_HEADERS'(1) << idx_q);
          mask_n = rem;
          idx_n  = lowest(rem);
          cnt_n  = '0;
          if (rem == '0) state_n = FINISH;
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so a new header follows
  // the previous one without a bubble and everything holds while stalled.
  assign addr_n = offs_n[idx_n] + cnt_n[AW-1:0];
  assign last_n = (state_n == EMIT) && (cnt_n == hdr_len(idx_n) - 16'd1) &&
                  ((mask_n & ~(NUM_HEADERS'(1) << idx_n)) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      offs_q       <= '0;
      mask_q       <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      len_o        <= '0;
      error_o      <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      strm.valid_o <= 1'b0;
      strm.last_o  <= 1'b0;
      strm.byte_o  <= '0;
    end else begin
      state_q      <= state_n;
      snap_q       <= snap_n;
      offs_q       <= offs_n;
      mask_q       <= mask_n;
      idx_q        <= idx_n;
      cnt_q        <= cnt_n;
      len_o        <= len_n;
      error_o      <= err_n;
      busy_o       <= (state_n == EMIT);
      done_o       <= (state_n == FINISH);
      strm.valid_o <= (state_n == EMIT);
      strm.last_o  <= last_n;
      strm.byte_o  <= (state_n == EMIT) ? snap_n[addr_n] : 8'h00;
    end
  end
endmodule

// File: tb/tb_fixed_deparser.sv
module tb_fixed_deparser;
  localparam int          NH  = 3;
  localparam int          HML = 64;
  localparam logic [31:0] NO  = 32'hFFFF_FFFF;

  typedef struct packed { logic [7:0] b; logic l; } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [HML-1:0][7:0]   win;
  logic [NH-1:0][31:0]   offs;
  logic                  busy, done, err;
  logic [15:0]           len;

  fixed_deparser_if strm();

  fixed_deparser dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .pkt_hdr_i    (win),
    .parsed_hdrs_i(offs),
    .strm         (strm),
    .busy_o       (busy),
    .done_o       (done),
    .len_o        (len),
    .error_o      (err)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   checks = 0, fails = 0, nxfer = 0;
  bit   tog = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ready driver: toggles every cycle when tog is set, else held high
  initial begin
    strm.ready_i = 1'b1;
    forever begin
      @(posedge clk); #2;
      strm.ready_i = tog ? ~strm.ready_i : 1'b1;
    end
  end

  // stream monitor: scoreboard pop on transfer, hold check on stall
  initial begin
    bit         stall;
    logic [7:0] hb;
    logic       hl;
    exp_t       e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) stall = 1'b0;
      else if (strm.valid_o) begin
        if (stall) begin
          chk("hold_byte", strm.byte_o, hb);
          chk("hold_last", strm.last_o, hl);
        end
        stall = !strm.ready_i;
        hb    = strm.byte_o;
        hl    = strm.last_o;
        if (strm.ready_i) begin
          nxfer++;
          if (q.size() == 0) chk("extra_byte", 1, 0);
          else begin
            e = q.pop_front();
            chk("byte", strm.byte_o, e.b);
            chk("last", strm.last_o, e.l);
          end
        end
      end else stall = 1'b0;
    end
  end

  task automatic launch(input logic [31:0] o0, o1, o2, input bit t,
                        output int n, output bit e);
    int          lens [3] = '{14, 20, 8};
    logic [31:0] o    [3];
    exp_t        x;
    o[0] = o0; o[1] = o1; o[2] = o2;
    n = 0; e = 1'b0;
    q.delete();
    nxfer = 0;
    for (int i = 0; i < 3; i++) begin
      if (o[i] != NO) begin
        if (longint'(o[i]) + lens[i] <= HML) begin
          for (int j = 0; j < lens[i]; j++) begin
            x.b = win[int'(o[i]) + j];
            x.l = 1'b0;
            q.push_back(x);
            n++;
          end
        end else e = 1'b1;
      end
    end
    if (n > 0) begin
      x = q.pop_back();
      x.l = 1'b1;
      q.push_back(x);
    end
    tog  = t;
    offs = {o2, o1, o0};
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic run(input string nm, input logic [31:0] o0, o1, o2, input bit t);
    int n, cyc;
    bit e;
    launch(o0, o1, o2, t, n, e);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 400);
    chk({nm, "_done"}, done, 1);
    if (!t) chk({nm, "_latency"}, cyc, n + 1);
    chk({nm, "_len"}, len, n);
    chk({nm, "_err"}, err, e);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_valid_at_done"}, strm.valid_o, 0);
    chk({nm, "_pending"}, q.size(), 0);
    tog = 1'b0;
    @(negedge clk);
    chk({nm, "_len_held"}, len, n);
    chk({nm, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int n, w;
    bit e;
    for (int k = 0; k < HML; k++) win[k] = 8'(k);
    offs = {NO, NO, NO};

    #3;
    chk("rst_valid", strm.valid_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_len", len, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #2 rst = 1'b0;

    run("s1_eth_ip",   32'd0, 32'd14, NO, 1'b0);
    run("s2_toggle",   32'd0, 32'd14, NO, 1'b1);
    run("s3_none",     NO, NO, NO, 1'b0);
    run("s4_udp",      NO, NO, 32'd10, 1'b0);
    run("s5_overrun",  32'd0, 32'd50, NO, 1'b0);
    run("s_exact_fit", NO, 32'd44, 32'd56, 1'b0);
    run("s_wrap_off",  32'hFFFF_FFF8, 32'd0, NO, 1'b0);

    for (int k = 0; k < HML; k++) win[k] = 8'($urandom);
    run("s_overlap",   32'd0, 32'd0, 32'd4, 1'b0);
    run("s_all_tog",   32'd3, 32'd17, 32'd37, 1'b1);

    // abort mid-stream with reset
    for (int k = 0; k < HML; k++) win[k] = 8'(k);
    launch(32'd0, 32'd14, NO, 1'b0, n, e);
    w = 0;
    while (nxfer < 6 && w < 100) begin @(negedge clk); w++; end
    chk("s6_reach_byte5", nxfer >= 6, 1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("s6_rst_valid", strm.valid_o, 0);
    chk("s6_rst_last", strm.last_o, 0);
    chk("s6_rst_byte", strm.byte_o, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_done", done, 0);
    chk("s6_rst_len", len, 0);
    q.delete();
    @(posedge clk); #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s6_no_done", done, 0);
      chk("s6_idle_valid", strm.valid_o, 0);
    end
    run("s6_restart", 32'd0, 32'd14, NO, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
